// File: rtl/mmind_solver.sv
// mmind_solver: bitwise Mastermind-style solver for an 8-bit hidden answer.
// It first issues guess 0x00 to learn s0, the number of zero bits in the answer.
// It then probes single bits (1<<i) and compares each score against s0+1 / s0-1.
// Optional macro MMIND_SOLVER_DEDUCE_EN: answer[7] is inferred from the ones
// count instead of being probed.
// Ports:
//   clk, reset (async, active-low)
//   start                       - begin a solve (accepted in IDLE/DONE/ERR)
//   guess[7:0], guess_valid     - pattern awaiting a score
//   score[3:0], score_valid     - score strobe, accepted only while guess_valid=1
//   answer[7:0], done, error    - result and status
//   guess_count[3:0]            - scores accepted since start, saturating at 15
module mmind_solver (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic [7:0] guess,
  output logic       guess_valid,
  input  logic [3:0] score,
  input  logic       score_valid,
  output logic [7:0] answer,
  output logic       done,
  output logic       error,
  output logic [3:0] guess_count
);

  localparam int unsigned GW = 8;
  localparam int unsigned SW = 4;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_EVAL  = 3'd2;
  localparam logic [2:0] S_DONE  = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [GW-1:0] guess_q, guess_d;
  logic [GW-1:0] answer_q, answer_d;
  logic [SW-1:0] s0_q, s0_d;
  logic [SW-1:0] score_q, score_d;
  logic [SW-1:0] count_q, count_d;
  logic          gv_q, gv_d;
  logic          done_q, done_d;
  logic          err_q, err_d;

  logic          go_err_c, go_done_c, go_issue_c, probe_ok_c;
  logic [GW-1:0] ans_new_c;
`ifdef MMIND_SOLVER_DEDUCE_EN
  logic [SW-1:0] ones_c;
  logic [SW-1:0] zeros_exp_c;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      guess_q  <= '0;
      answer_q <= '0;
      s0_q     <= '0;
      score_q  <= '0;
      count_q  <= '0;
      gv_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      guess_q  <= guess_d;
      answer_q <= answer_d;
      s0_q     <= s0_d;
      score_q  <= score_d;
      count_q  <= count_d;
      gv_q     <= gv_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    guess_d    = guess_q;
    answer_d   = answer_q;
    s0_d       = s0_q;
    score_d    = score_q;
    count_d    = count_q;
    gv_d       = gv_q;
    done_d     = done_q;
    err_d      = err_q;
    go_err_c   = 1'b0;
    go_done_c  = 1'b0;
    go_issue_c = 1'b0;
    probe_ok_c = 1'b0;
    ans_new_c  = answer_q;
`ifdef MMIND_SOLVER_DEDUCE_EN
    ones_c      = '0;
    zeros_exp_c = '0;
`endif

    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start) begin
          state_d  = S_ISSUE;
          guess_d  = '0;
          answer_d = '0;
          count_d  = '0;
          gv_d     = 1'b1;
          done_d   = 1'b0;
          err_d    = 1'b0;
        end
      end

      S_ISSUE: begin
        if (score_valid) begin
          score_d = score;
          count_d = (count_q == 4'd15) ? count_q : SW'(count_q + 4'd1);
          gv_d    = 1'b0;
          state_d = S_EVAL;
        end
      end

      S_EVAL: begin
        if (score_q > 4'd8) begin
          go_err_c = 1'b1;
        end else if (guess_q == '0) begin
          // All-zero guess measures the zero-bit count; extremes solve at once
          s0_d = score_q;
          if (score_q == 4'd8) begin
            answer_d  = 8'h00;
            go_done_c = 1'b1;
          end else if (score_q == 4'd0) begin
            answer_d  = 8'hFF;
            go_done_c = 1'b1;
          end else begin
            guess_d    = 8'h01;
            go_issue_c = 1'b1;
          end
        end else begin
          // Flipping bit i to 1 gains a match iff answer[i]=1, loses one iff 0
          if (score_q == SW'(s0_q + 4'd1)) begin
            probe_ok_c = 1'b1;
            ans_new_c  = answer_q | guess_q;
          end else if (score_q == SW'(s0_q - 4'd1)) begin
            probe_ok_c = 1'b1;
          end

          if (!probe_ok_c) begin
            go_err_c = 1'b1;
          end else begin
            answer_d = ans_new_c;
`ifdef MMIND_SOLVER_DEDUCE_EN
            if (guess_q[6]) begin
              // Total ones must be 8-s0; bit 7 is whatever remains (0 or 1)
              for (int i = 0; i < 7; i++) ones_c = SW'(ones_c + SW'(ans_new_c[i]));
              zeros_exp_c = SW'(4'd8 - s0_q);
              if (ones_c == zeros_exp_c) begin
                go_done_c = 1'b1;
              end else if (SW'(ones_c + 4'd1) == zeros_exp_c) begin
                answer_d[7] = 1'b1;
                go_done_c   = 1'b1;
              end else begin
                go_err_c = 1'b1;
              end
            end else begin
              guess_d    = {guess_q[GW-2:0], 1'b0};
              go_issue_c = 1'b1;
            end
`else
            if (guess_q[7]) begin
              go_done_c = 1'b1;
            end else begin
              guess_d    = {guess_q[GW-2:0], 1'b0};
              go_issue_c = 1'b1;
            end
`endif
          end
        end

        if (go_err_c) begin
          state_d = S_ERR;
          done_d  = 1'b1;
          err_d   = 1'b1;
          gv_d    = 1'b0;
        end else if (go_done_c) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          err_d   = 1'b0;
          gv_d    = 1'b0;
        end else if (go_issue_c) begin
          state_d = S_ISSUE;
          gv_d    = 1'b1;
        end
      end

      default: begin
        state_d = S_IDLE;
        gv_d    = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  assign guess       = guess_q;
  assign guess_valid = gv_q;
  assign answer      = answer_q;
  assign done        = done_q;
  assign error       = err_q;
  assign guess_count = count_q;

endmodule

// File: tb/tb_mmind_solver.sv
// Directed bench for mmind_solver: solves, error paths, ignored strobes, async reset.
module tb_mmind_solver;

  logic       clk;
  logic       reset;
  logic       start;
  logic [7:0] guess;
  logic       guess_valid;
  logic [3:0] score;
  logic       score_valid;
  logic [7:0] answer;
  logic       done;
  logic       error;
  logic [3:0] guess_count;

  int checks   = 0;
  int failures = 0;

`ifdef MMIND_SOLVER_DEDUCE_EN
  localparam int NP = 8;
`else
  localparam int NP = 9;
`endif

  logic [7:0] g_tab [9] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};
  logic [3:0] s_tab [9] = '{4'd4, 4'd5, 4'd3, 4'd5, 4'd3, 4'd3, 4'd5, 4'd3, 4'd5};

  mmind_solver dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .guess       (guess),
    .guess_valid (guess_valid),
    .score       (score),
    .score_valid (score_valid),
    .answer      (answer),
    .done        (done),
    .error       (error),
    .guess_count (guess_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One-cycle start pulse; guess_valid must be up one cycle later with guess 0x00
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_gv", 32'(guess_valid), 32'd1);
    chk("start_guess", 32'(guess), 32'h00);
    chk("start_count", 32'(guess_count), 32'd0);
    chk("start_done", 32'(done), 32'd0);
  endtask

  // Score one guess; checks fixed latency (EVAL cycle with guess_valid=0)
  task automatic step(input logic [7:0] g, input logic [3:0] s, input logic [3:0] n);
    chk("step_gv", 32'(guess_valid), 32'd1);
    chk("step_guess", 32'(guess), 32'(g));
    chk("step_count", 32'(guess_count), 32'(n));
    score       = s;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    chk("eval_gv", 32'(guess_valid), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    reset       = 1'b0;
    start       = 1'b0;
    score       = '0;
    score_valid = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_gv", 32'(guess_valid), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_answer", 32'(answer), 32'h00);
    chk("rst_count", 32'(guess_count), 32'd0);
    reset = 1'b1;

    // Strobe while idle is ignored, block stays idle
    score       = 4'd3;
    score_valid = 1'b1;
    @(negedge clk);
    score_valid = 1'b0;
    @(negedge clk);
    chk("idle_gv", 32'(guess_valid), 32'd0);
    chk("idle_count", 32'(guess_count), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // Full solve of 0xA5
    do_start();
    for (int i = 0; i < NP; i++) step(g_tab[i], s_tab[i], 4'(i));
    chk("a5_done", 32'(done), 32'd1);
    chk("a5_error", 32'(error), 32'd0);
    chk("a5_gv", 32'(guess_valid), 32'd0);
    chk("a5_answer", 32'(answer), 32'hA5);
    chk("a5_count", 32'(guess_count), 32'(NP));
    @(negedge clk);
    chk("a5_hold", 32'(answer), 32'hA5);

    // Answer 0x00 and 0xFF
    do_start();
    step(8'h00, 4'd8, 4'd0);
    chk("z_done", 32'(done), 32'd1);
    chk("z_error", 32'(error), 32'd0);
    chk("z_answer", 32'(answer), 32'h00);
    chk("z_count", 32'(guess_count), 32'd1);
    do_start();
    step(8'h00, 4'd0, 4'd0);
    chk("f_done", 32'(done), 32'd1);
    chk("f_answer", 32'(answer), 32'hFF);
    chk("f_count", 32'(guess_count), 32'd1);

    // Strobe during EVAL and start during ISSUE are ignored; then inconsistent score
    do_start();
    score       = 4'd4;
    score_valid = 1'b1;
    @(negedge clk);
    score = 4'd9;
    chk("ign_eval_gv", 32'(guess_valid), 32'd0);
    @(negedge clk);
    score_valid = 1'b0;
    chk("ign_gv", 32'(guess_valid), 32'd1);
    chk("ign_guess", 32'(guess), 32'h01);
    chk("ign_count", 32'(guess_count), 32'd1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ign_start_guess", 32'(guess), 32'h01);
    chk("ign_start_gv", 32'(guess_valid), 32'd1);
    chk("ign_start_count", 32'(guess_count), 32'd1);
    step(8'h01, 4'd4, 4'd1);
    chk("inc_done", 32'(done), 32'd1);
    chk("inc_error", 32'(error), 32'd1);
    chk("inc_gv", 32'(guess_valid), 32'd0);
    chk("inc_count", 32'(guess_count), 32'd2);

    // Out-of-range score on the first guess
    do_start();
    step(8'h00, 4'd9, 4'd0);
    chk("s9_done", 32'(done), 32'd1);
    chk("s9_error", 32'(error), 32'd1);
    chk("s9_count", 32'(guess_count), 32'd1);

    // Asynchronous reset while guess 0x04 awaits a score
    do_start();
    step(8'h00, 4'd4, 4'd0);
    step(8'h01, 4'd5, 4'd1);
    step(8'h02, 4'd3, 4'd2);
    chk("pre_rst_guess", 32'(guess), 32'h04);
    chk("pre_rst_answer", 32'(answer), 32'h01);
    #2 reset = 1'b0;
    #1;
    chk("arst_gv", 32'(guess_valid), 32'd0);
    chk("arst_guess", 32'(guess), 32'h00);
    chk("arst_answer", 32'(answer), 32'h00);
    chk("arst_done", 32'(done), 32'd0);
    chk("arst_error", 32'(error), 32'd0);
    chk("arst_count", 32'(guess_count), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_gv", 32'(guess_valid), 32'd0);
    do_start();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
